// File: rtl/clkgen_pkg.sv
// Shared state encoding, counter widths and sizing helper for clkgen_sequencer.
package clkgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int LOST_CNT_W = 8;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkgen_div.sv
// One channel of clkgen_sequencer: divisor latch, free-running divide counter
// and a registered single-cycle clock-enable strobe.
module clkgen_div
  import clkgen_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             en
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] last_w;
  logic             en_q;

  // Divisors 0 and 1 both collapse to a terminal count of 0 (strobe every cycle).
  always_comb begin
    last_w = '0;
    if (div_q > DIV_W'(1)) begin
      last_w = div_q - DIV_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst || hold) begin
      div_q <= div;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else if (cnt_q == last_w) begin
      cnt_q <= '0;
      en_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
      en_q  <= 1'b0;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/clkgen_sequencer.sv
// Lock-qualified reset sequencer and per-channel clock-enable generator behind the PLL.
// Define CLKGEN_LOCK_LOG_EN to build the saturating lost-lock counter; otherwise it reads 0.
module clkgen_sequencer
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int RELEASE_GAP = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    pll_locked,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       ch_rst,
  output logic [NUM_CH-1:0]       ch_en,
  output logic                    ready,
  output logic [LOST_CNT_W-1:0]   lost_lock_cnt
);

  localparam int STAB_W = cnt_w(LOCK_CYCLES);
  localparam int GAP_W  = cnt_w(RELEASE_GAP);
  localparam int REL_W  = cnt_w(NUM_CH);

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(RELEASE_GAP - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(NUM_CH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;

  state_e                 state_q;
  logic [STAB_W-1:0]      stab_q;
  logic [GAP_W-1:0]       gap_q;
  logic [REL_W-1:0]       rel_q;
  logic [REL_W-1:0]       rel_nxt_w;
  logic [NUM_CH-1:0]      ch_rst_q;
  logic                   ready_q;
  logic                   loss_w;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lk_s      = sync_q[SYNC_STAGES-1];
  assign rel_nxt_w = rel_q + REL_W'(1);

  // Loss of lock while any channel may be running overrides every other event.
  assign loss_w = ((state_q == RELEASE) || (state_q == RUN)) && !lk_s;

  always_ff @(posedge refclk) begin
    if (rst || loss_w) begin
      state_q  <= WAIT_LOCK;
      stab_q   <= '0;
      gap_q    <= '0;
      rel_q    <= '0;
      ch_rst_q <= '1;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          stab_q <= '0;
          if (lk_s) begin
            state_q <= STABLE;
          end
        end
        STABLE: begin
          if (!lk_s) begin
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
          end else if (stab_q == STAB_LAST) begin
            stab_q      <= '0;
            gap_q       <= '0;
            rel_q       <= '0;
            ch_rst_q[0] <= 1'b0;
            if (NUM_CH == 1) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end else begin
              state_q <= RELEASE;
            end
          end else begin
            stab_q <= stab_q + STAB_W'(1);
          end
        end
        RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_q    <= '0;
            rel_q    <= rel_nxt_w;
            ch_rst_q <= ch_rst_q & ~(NUM_CH'(1) << rel_nxt_w);
            if (rel_nxt_w == REL_LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  // A channel's divider is also held on the edge that reasserts its reset,
  // so no strobe can coincide with ch_rst going high.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clkgen_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .refclk(refclk),
      .rst   (rst),
      .hold  (ch_rst_q[k] | loss_w),
      .div   (div_i[k*DIV_W +: DIV_W]),
      .en    (ch_en[k])
    );
  end

`ifdef CLKGEN_LOCK_LOG_EN
  logic [LOST_CNT_W-1:0] lost_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      lost_q <= '0;
    end else if (loss_w && (state_q == RUN) && (lost_q != '1)) begin
      lost_q <= lost_q + LOST_CNT_W'(1);
    end
  end

  assign lost_lock_cnt = lost_q;
`else
  assign lost_lock_cnt = '0;
`endif

  assign ch_rst = ch_rst_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_clkgen_sequencer.sv
// Directed bench for clkgen_sequencer: timeline vector table plus hand-written
// sequences for lock glitches, loss of lock, divisor freezing and mid-sequence reset.
module tb_clkgen_sequencer;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

`ifdef CLKGEN_LOCK_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic                    refclk     = 1'b0;
  logic                    rst        = 1'b1;
  logic                    pll_locked = 1'b0;
  logic [NUM_CH*DIV_W-1:0] div        = {8'd10, 8'd3, 8'd1, 8'd0};
  logic [NUM_CH-1:0]       ch_rst;
  logic [NUM_CH-1:0]       ch_en;
  logic                    ready;
  logic [7:0]              lost_lock_cnt;

  int cyc;
  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic [7:0] cyc;
    logic [3:0] rst_e;
    logic [3:0] en_e;
    logic       rdy_e;
  } vec_t;

  vec_t tv [17];

  always #5 refclk = ~refclk;

  clkgen_sequencer #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .LOCK_CYCLES(8),
    .RELEASE_GAP(4),
    .SYNC_STAGES(2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .div_i        (div),
    .ch_rst       (ch_rst),
    .ch_en        (ch_en),
    .ready        (ready),
    .lost_lock_cnt(lost_lock_cnt)
  );

  function automatic logic [31:0] lost_exp(input int n);
    if (!LOG_EN) return 32'd0;
    return (n > 255) ? 32'd255 : 32'(n);
  endfunction

  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    rst        = 1'b1;
    pll_locked = 1'b0;
    step();
    step();
    step();
    chk({nm, "_rst_ch_rst"}, 32'(ch_rst), 32'hF);
    chk({nm, "_rst_ch_en"}, 32'(ch_en), 32'h0);
    chk({nm, "_rst_ready"}, 32'(ready), 32'h0);
    chk({nm, "_rst_lost"}, 32'(lost_lock_cnt), 32'h0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_rst(input logic [3:0] target, input int budget, input string nm);
    int k;
    k = 0;
    while ((ch_rst !== target) && (k < budget)) begin
      step();
      k++;
    end
    chk({nm, "_wait_ch_rst"}, 32'(ch_rst), 32'(target));
  endtask

  task automatic wait_ready(input int budget, input string nm);
    int k;
    k = 0;
    while ((ready !== 1'b1) && (k < budget)) begin
      step();
      k++;
    end
    chk({nm, "_wait_ready"}, 32'(ready), 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;

    // Cold start with divisors {10,3,1,0}: lock sampled at edge 10.
    tv[0]  = '{8'd11, 4'hF, 4'h0, 1'b0};
    tv[1]  = '{8'd19, 4'hF, 4'h0, 1'b0};
    tv[2]  = '{8'd20, 4'hE, 4'h0, 1'b0};
    tv[3]  = '{8'd21, 4'hE, 4'h1, 1'b0};
    tv[4]  = '{8'd23, 4'hE, 4'h1, 1'b0};
    tv[5]  = '{8'd24, 4'hC, 4'h1, 1'b0};
    tv[6]  = '{8'd25, 4'hC, 4'h3, 1'b0};
    tv[7]  = '{8'd28, 4'h8, 4'h3, 1'b0};
    tv[8]  = '{8'd30, 4'h8, 4'h3, 1'b0};
    tv[9]  = '{8'd31, 4'h8, 4'h7, 1'b0};
    tv[10] = '{8'd32, 4'h0, 4'h3, 1'b1};
    tv[11] = '{8'd33, 4'h0, 4'h3, 1'b1};
    tv[12] = '{8'd34, 4'h0, 4'h7, 1'b1};
    tv[13] = '{8'd41, 4'h0, 4'h3, 1'b1};
    tv[14] = '{8'd42, 4'h0, 4'hB, 1'b1};
    tv[15] = '{8'd43, 4'h0, 4'h7, 1'b1};
    tv[16] = '{8'd52, 4'h0, 4'hF, 1'b1};

    // One-cycle lock glitch while STABLE.
    do_reset("glitch");
    while (cyc < 9) step();
    pll_locked = 1'b1;
    while (cyc < 14) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    while (cyc < 20) step();
    chk("glitch_no_rel_20", 32'(ch_rst), 32'hF);
    while (cyc < 25) step();
    chk("glitch_no_rel_25", 32'(ch_rst), 32'hF);
    step();
    chk("glitch_rel0_26", 32'(ch_rst), 32'hE);
    while (cyc < 37) step();
    chk("glitch_ready_37", 32'(ready), 32'h0);
    step();
    chk("glitch_ready_38", 32'(ready), 32'h1);
    chk("glitch_all_rel_38", 32'(ch_rst), 32'h0);

    // Cold start timeline from the vector table.
    do_reset("cold");
    while (cyc < 9) step();
    pll_locked = 1'b1;
    for (int i = 0; i < 17; i++) begin
      while (cyc < int'(tv[i].cyc)) step();
      chk("cold_ch_rst", 32'(ch_rst), 32'(tv[i].rst_e));
      chk("cold_ch_en", 32'(ch_en), 32'(tv[i].en_e));
      chk("cold_ready", 32'(ready), 32'(tv[i].rdy_e));
    end
    chk("cold_lost", 32'(lost_lock_cnt), 32'h0);

    // Divisor change in RUN is ignored: channel 3 keeps period 10.
    div[31:24] = 8'd5;
    while (cyc < 75) begin
      step();
      chk("run_div_frozen", 32'(ch_en[3]), 32'(((cyc - 42) % 10) == 0));
    end

    // Loss of lock in RUN for 20 sampled cycles (edges 76..95).
    pll_locked = 1'b0;
    step();
    step();
    chk("loss_still_run_rst", 32'(ch_rst), 32'h0);
    chk("loss_still_run_rdy", 32'(ready), 32'h1);
    step();
    chk("loss_ch_rst", 32'(ch_rst), 32'hF);
    chk("loss_ready", 32'(ready), 32'h0);
    chk("loss_ch_en", 32'(ch_en), 32'h0);
    chk("loss_lost_cnt", 32'(lost_lock_cnt), lost_exp(1));
    while (cyc < 95) begin
      step();
      chk("outage_ch_rst", 32'(ch_rst), 32'hF);
      chk("outage_ch_en", 32'(ch_en), 32'h0);
    end
    pll_locked = 1'b1;
    while (cyc < 105) step();
    chk("relock_hold_105", 32'(ch_rst), 32'hF);
    step();
    chk("relock_rel0_106", 32'(ch_rst), 32'hE);
    while (cyc < 117) step();
    chk("relock_rst_117", 32'(ch_rst), 32'h8);
    chk("relock_rdy_117", 32'(ready), 32'h0);
    step();
    chk("relock_rst_118", 32'(ch_rst), 32'h0);
    chk("relock_rdy_118", 32'(ready), 32'h1);
    while (cyc < 130) begin
      step();
      chk("relock_div5", 32'(ch_en[3]), 32'(((cyc - 118) % 5) == 0));
    end
    chk("relock_lost_cnt", 32'(lost_lock_cnt), lost_exp(1));

    // Second loss, then rst while RELEASE has freed channels 0 and 1.
    pll_locked = 1'b0;
    wait_rst(4'hF, 10, "loss2");
    chk("loss2_lost_cnt", 32'(lost_lock_cnt), lost_exp(2));
    pll_locked = 1'b1;
    wait_rst(4'hC, 40, "rel1");
    rst = 1'b1;
    step();
    chk("midrst_ch_rst", 32'(ch_rst), 32'hF);
    chk("midrst_ch_en", 32'(ch_en), 32'h0);
    chk("midrst_ready", 32'(ready), 32'h0);
    chk("midrst_lost", 32'(lost_lock_cnt), 32'h0);
    step();
    chk("midrst_hold_ch_rst", 32'(ch_rst), 32'hF);
    chk("midrst_hold_ready", 32'(ready), 32'h0);
    rst = 1'b0;

    // 300 RUN lock losses saturate the counter.
    for (int n = 1; n <= 300; n++) begin
      wait_ready(60, "sat");
      pll_locked = 1'b0;
      wait_rst(4'hF, 10, "sat_loss");
      chk("sat_lost_cnt", 32'(lost_lock_cnt), lost_exp(n));
      pll_locked = 1'b1;
      if (n_bad > 50) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
